// File: rtl/emu_step_sequencer.sv
// Host-to-emulation-wrapper transactor: streams stimulus bytes in, runs one DUT clock per step, streams output bytes back.
// Optional step counter and LED output are enabled by defining EMU_STEP_CNT_EN.
module emu_step_sequencer #(
  parameter int NUM_STIM = 1,
  parameter int NUM_OUT  = 2,
  parameter int CLK_HALF = 1,
  parameter int ADDR_W   = 3
) (
  input  logic              clk_emu,
  input  logic              reset_n_emu,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        Din_emu,
  input  logic [7:0]        Dout_emu,
  output logic [ADDR_W-1:0] Addr_emu,
  output logic              load_emu,
  output logic              get_emu,
  output logic              clk_dut
`ifdef EMU_STEP_CNT_EN
  ,
  output logic [15:0]       step_cnt,
  output logic              clk_LED
`endif
);

  localparam int SW = (NUM_STIM > 1) ? $clog2(NUM_STIM) : 1;
  localparam int OW = (NUM_OUT  > 1) ? $clog2(NUM_OUT)  : 1;
  localparam int HW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

  localparam logic [SW-1:0] STIM_LAST = SW'(NUM_STIM - 1);
  localparam logic [OW-1:0] OUT_LAST  = OW'(NUM_OUT - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_HALF - 1);

  typedef enum logic [3:0] {
    S_RX, S_WR, S_LOAD, S_CLKH, S_CLKL, S_GET, S_ADDR, S_WAIT, S_TX
  } state_t;

  state_t        state;
  logic [SW-1:0] stim_idx;
  logic [OW-1:0] out_idx;
  logic [HW-1:0] half_cnt;

  assign rx_ready = (state == S_RX);

`ifdef EMU_STEP_CNT_EN
  assign clk_LED = step_cnt[3];
`endif

  // Wrapper-facing outputs are set on entry to the state that owns them so they are glitch-free registers.
  always_ff @(posedge clk_emu or negedge reset_n_emu) begin
    if (!reset_n_emu) begin
      state    <= S_RX;
      stim_idx <= '0;
      out_idx  <= '0;
      half_cnt <= '0;
      Din_emu  <= '0;
      Addr_emu <= '0;
      load_emu <= 1'b0;
      get_emu  <= 1'b0;
      clk_dut  <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
`ifdef EMU_STEP_CNT_EN
      step_cnt <= '0;
`endif
    end else begin
      case (state)
        S_RX: begin
          if (rx_valid) begin
            Din_emu  <= rx_data;
            Addr_emu <= ADDR_W'(stim_idx);
            state    <= S_WR;
          end
        end
        S_WR: begin
          if (stim_idx == STIM_LAST) begin
            stim_idx <= '0;
            load_emu <= 1'b1;
            state    <= S_LOAD;
          end else begin
            stim_idx <= stim_idx + 1'b1;
            state    <= S_RX;
          end
        end
        S_LOAD: begin
          load_emu <= 1'b0;
          clk_dut  <= 1'b1;
          half_cnt <= '0;
          state    <= S_CLKH;
        end
        S_CLKH: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            clk_dut  <= 1'b0;
            state    <= S_CLKL;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        S_CLKL: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            get_emu  <= 1'b1;
            state    <= S_GET;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        S_GET: begin
          get_emu  <= 1'b0;
          Addr_emu <= ADDR_W'(out_idx);
          state    <= S_ADDR;
`ifdef EMU_STEP_CNT_EN
          step_cnt <= step_cnt + 16'd1;
`endif
        end
        S_ADDR: state <= S_WAIT;
        // Dout_emu is registered in the wrapper, so it is valid one cycle after the address.
        S_WAIT: begin
          tx_data  <= Dout_emu;
          tx_valid <= 1'b1;
          state    <= S_TX;
        end
        S_TX: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (out_idx == OUT_LAST) begin
              out_idx  <= '0;
              stim_idx <= '0;
              state    <= S_RX;
            end else begin
              out_idx  <= out_idx + 1'b1;
              Addr_emu <= ADDR_W'(out_idx + 1'b1);
              state    <= S_ADDR;
            end
          end
        end
        default: state <= S_RX;
      endcase
    end
  end

endmodule

// File: tb/tb_emu_step_sequencer.sv
// Self-checking bench for emu_step_sequencer: default instance with a wrapper model, plus a NUM_STIM=2/CLK_HALF=3 instance.
module tb_emu_step_sequencer;

  localparam int LAT_A = 5 + 2 * 1;
  localparam int LAT_B = 5 + 2 * 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] rx_data, tx_data, din, dout;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;
  logic [2:0] addr;
  logic       load, get, clk_dut;

  logic [7:0] rx_data_b, tx_data_b, din_b, dout_b;
  logic       rx_valid_b, rx_ready_b, tx_valid_b, tx_ready_b;
  logic [2:0] addr_b;
  logic       load_b, get_b, clk_dut_b;

`ifdef EMU_STEP_CNT_EN
  logic [15:0] step_cnt, step_cnt_b;
  logic        clk_led, clk_led_b;
`endif

  emu_step_sequencer dut (
    .clk_emu(clk), .reset_n_emu(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .Din_emu(din), .Dout_emu(dout), .Addr_emu(addr),
    .load_emu(load), .get_emu(get), .clk_dut(clk_dut)
`ifdef EMU_STEP_CNT_EN
    , .step_cnt(step_cnt), .clk_LED(clk_led)
`endif
  );

  emu_step_sequencer #(.NUM_STIM(2), .NUM_OUT(2), .CLK_HALF(3), .ADDR_W(3)) dut_b (
    .clk_emu(clk), .reset_n_emu(rst_n),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .Din_emu(din_b), .Dout_emu(dout_b), .Addr_emu(addr_b),
    .load_emu(load_b), .get_emu(get_b), .clk_dut(clk_dut_b)
`ifdef EMU_STEP_CNT_EN
    , .step_cnt(step_cnt_b), .clk_LED(clk_led_b)
`endif
  );

  // Wrapper models: stimIn rewritten every cycle, applied on load, outputs captured on get, registered read-back.
  logic [7:0] stim_mem[8];
  logic [7:0] vect_next[8];
  logic [7:0] vect_cur[8];
  logic [7:0] applied;
  logic [7:0] stim_mem_b[8];
  logic [7:0] applied_b0, applied_b1;

  always @(posedge clk) begin
    stim_mem[addr] <= din;
    if (load) applied <= stim_mem[0];
    if (get) vect_cur <= vect_next;
    dout <= vect_cur[addr];
    stim_mem_b[addr_b] <= din_b;
    if (load_b) begin
      applied_b0 <= stim_mem_b[0];
      applied_b1 <= stim_mem_b[1];
    end
    dout_b <= 8'hA0 ^ {5'b0, addr_b};
  end

  int cyc = 0, load_cnt = 0, get_cnt = 0, hi_cnt = 0, both_cnt = 0, t_fall = 0, t_get = 0;
  int load_cnt_b = 0, hi_cnt_b = 0, t_fall_b = 0, t_get_b = 0;
  logic clkd_prev = 1'b0, clkd_prev_b = 1'b0;
  logic [7:0] got[$];
  logic [7:0] got_b[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (load) load_cnt <= load_cnt + 1;
    if (get) get_cnt <= get_cnt + 1;
    if (get) t_get <= cyc;
    if (clk_dut) hi_cnt <= hi_cnt + 1;
    if (load && get) both_cnt <= both_cnt + 1;
    if (clkd_prev && !clk_dut) t_fall <= cyc;
    clkd_prev <= clk_dut;
    if (tx_valid && tx_ready) got.push_back(tx_data);
    if (load_b) load_cnt_b <= load_cnt_b + 1;
    if (get_b) t_get_b <= cyc;
    if (clk_dut_b) hi_cnt_b <= hi_cnt_b + 1;
    if (clkd_prev_b && !clk_dut_b) t_fall_b <= cyc;
    clkd_prev_b <= clk_dut_b;
    if (tx_valid_b && tx_ready_b) got_b.push_back(tx_data_b);
  end

  int errors = 0, checks = 0, steps_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic run_step(input logic [7:0] b, input logic [7:0] v0, input logic [7:0] v1, input int bp);
    int n, lb, gb, hb, bb, qb;
    vect_next[0] = v0;
    vect_next[1] = v1;
    @(negedge clk);
    check("rx_ready_idle", 32'(rx_ready), 1);
    lb = load_cnt; gb = get_cnt; hb = hi_cnt; bb = both_cnt; qb = got.size();
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    check("din", 32'(din), 32'(b));
    check("addr_wr", 32'(addr), 0);
    n = 0;
    while (!tx_valid && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    check("latency", n, LAT_A);
    check("applied", 32'(applied), 32'(b));
    if (bp > 0) begin
      tx_ready = 1'b0;
      repeat (bp) begin
        @(negedge clk);
        check("bp_valid", 32'(tx_valid), 1);
        check("bp_data", 32'(tx_data), 32'(v0));
        check("bp_rx_ready", 32'(rx_ready), 0);
      end
      tx_ready = 1'b1;
    end
    n = 0;
    while (!rx_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("step_done", 32'(rx_ready), 1);
    check("tx_count", got.size() - qb, 2);
    if (got.size() >= qb + 2) begin
      check("tx0", 32'(got[qb]), 32'(v0));
      check("tx1", 32'(got[qb+1]), 32'(v1));
    end
    check("load_cycles", load_cnt - lb, 1);
    check("get_cycles", get_cnt - gb, 1);
    check("clk_hi_cycles", hi_cnt - hb, 1);
    check("load_get_overlap", both_cnt - bb, 0);
    check("clk_lo_cycles", t_get - t_fall, 1);
    steps_done++;
`ifdef EMU_STEP_CNT_EN
    check("step_cnt", 32'(step_cnt), steps_done);
    check("clk_led", 32'(clk_led), (steps_done >> 3) & 1);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, lb, hb, qb;
    logic [7:0] b0, b1;
    rst_n = 1'b0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
    rx_valid_b = 1'b0; rx_data_b = '0; tx_ready_b = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 1);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_din", 32'(din), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_load", 32'(load), 0);
    check("rst_get", 32'(get), 0);
    check("rst_clk_dut", 32'(clk_dut), 0);
    check("rst_rx_ready_b", 32'(rx_ready_b), 1);
    rst_n = 1'b1;

    run_step(8'h04, 8'h5A, 8'hC3, 0);
    run_step(8'h04, 8'h5A, 8'hC3, 10);

    // Reset in the middle of a step while clk_dut is high.
    @(negedge clk);
    rx_data = 8'h77;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    n = 0;
    while (!clk_dut && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("mid_clk_dut_high", 32'(clk_dut), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_clk_dut", 32'(clk_dut), 0);
    check("mid_rst_rx_ready", 32'(rx_ready), 1);
    check("mid_rst_load", 32'(load), 0);
    check("mid_rst_addr", 32'(addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    steps_done = 0;

    run_step(8'h04, 8'h5A, 8'hC3, 0);
    for (int i = 0; i < 18; i++)
      run_step(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    // Second instance: two stimulus bytes and a three-cycle clk_dut half period.
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    @(negedge clk);
    lb = load_cnt_b; hb = hi_cnt_b; qb = got_b.size();
    check("b_rx_ready0", 32'(rx_ready_b), 1);
    rx_data_b = b0;
    rx_valid_b = 1'b1;
    @(posedge clk);
    #1 rx_valid_b = 1'b0;
    check("b_din0", 32'(din_b), 32'(b0));
    check("b_addr0", 32'(addr_b), 0);
    n = 0;
    while (!rx_ready_b && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b_rx_ready1", 32'(rx_ready_b), 1);
    check("b_no_early_load", load_cnt_b - lb, 0);
    rx_data_b = b1;
    rx_valid_b = 1'b1;
    @(posedge clk);
    #1 rx_valid_b = 1'b0;
    check("b_din1", 32'(din_b), 32'(b1));
    check("b_addr1", 32'(addr_b), 1);
    n = 0;
    while (!tx_valid_b && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    check("b_latency", n, LAT_B);
    check("b_applied0", 32'(applied_b0), 32'(b0));
    check("b_applied1", 32'(applied_b1), 32'(b1));
    n = 0;
    while (!rx_ready_b && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("b_step_done", 32'(rx_ready_b), 1);
    check("b_load_cycles", load_cnt_b - lb, 1);
    check("b_clk_hi_cycles", hi_cnt_b - hb, 3);
    check("b_clk_lo_cycles", t_get_b - t_fall_b, 3);
    check("b_tx_count", got_b.size() - qb, 2);
    if (got_b.size() >= qb + 2) begin
      check("b_tx0", 32'(got_b[qb]), 32'hA0);
      check("b_tx1", 32'(got_b[qb+1]), 32'hA1);
    end
`ifdef EMU_STEP_CNT_EN
    check("b_step_cnt", 32'(step_cnt_b), 1);
    check("b_clk_led", 32'(clk_led_b), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
